rr_arbiter_sel_4ch: RTL and testbench

Round-robin arbiter that sits directly upstream of the 4:1 decoder/tri-state-buffer mux. It accepts four request lines and produces the 2-bit select that drives the mux. It also produces a one-hot grant and a busy qualifier, so the downstream consumer knows when the mux output is valid. The arbiter enforces bounded hold time and a one-cycle break-before-make gap between owners, so ownership of the shared tri-state bus never changes without an idle cycle.

---
 rtl/rr_arb_pkg.sv | 17 +
 rtl/rr_pick_4.sv | 27 ++
 rtl/rr_arbiter_sel_4ch.sv | 86 ++++++++
 tb/tb_rr_arbiter_sel_4ch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-channel round-robin select arbiter.
package rr_arb_pkg;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // One-hot channel code, bit order matches the downstream 4:1 decoder.
   function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
      return NUM_CH'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Rotating first-set picker: finds the first requesting channel starting at prio.
module rr_pick_4
   import rr_arb_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   prio,
   output logic              found,
   output logic [CH_W-1:0]   idx
);

   logic [CH_W-1:0] cand;

   // Scan from the farthest offset down so the nearest requester wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int j = NUM_CH - 1; j >= 0; j--) begin
         cand = prio + CH_W'(j);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_sel_4ch.sv
// Round-robin arbiter driving the 2-bit select of the shared 4:1 tri-state mux.
// Grants are hold-bounded and always separated by at least one idle cycle.
//
// state | meaning
// IDLE  | no owner; arbitrate among requesters starting at prio
// GRANT | channel sel owns the bus; release on done, request drop or hold limit
module rr_arbiter_sel_4ch
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              done,
   output logic [CH_W-1:0]   sel,
   output logic [NUM_CH-1:0] grant,
   output logic              busy
);

   localparam int CNT_W = $clog2(MAX_HOLD + 1);

   state_e            state_q;
   logic [CH_W-1:0]   sel_q;
   logic [NUM_CH-1:0] grant_q;
   logic              busy_q;
   logic [CH_W-1:0]   prio_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              pick_found;
   logic [CH_W-1:0]   pick_idx;
   logic              release_c;

   rr_pick_4 u_pick (
      .req   (req),
      .prio  (prio_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Owner gives up the bus when finished, no longer asking, or out of hold budget.
   assign release_c = done || !req[sel_q] || (cnt_q == CNT_W'(MAX_HOLD));

   // Arbitration FSM with registered outputs; sel is kept through idle so the mux stays stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
         prio_q  <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  sel_q   <= pick_idx;
                  grant_q <= ch_onehot(pick_idx);
                  busy_q  <= 1'b1;
                  cnt_q   <= CNT_W'(1);
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if (release_c) begin
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  prio_q  <= sel_q + CH_W'(1);
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign sel   = sel_q;
   assign grant = grant_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_rr_arbiter_sel_4ch.sv
// Self-checking bench for rr_arbiter_sel_4ch: vector table, corner sequences,
// a MAX_HOLD=1 instance, exhaustive picker check and randomized model compare.
module tb_rr_arbiter_sel_4ch;

   localparam int MAXH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       done = 1'b0;
   logic [1:0] sel;
   logic [3:0] grant;
   logic       busy;

   logic [3:0] req1 = 4'b0000;
   logic [1:0] sel1;
   logic [3:0] grant1;
   logic       busy1;

   logic [3:0] pk_req = 4'b0000;
   logic [1:0] pk_prio = 2'b00;
   logic       pk_found;
   logic [1:0] pk_idx;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // behavioural model state (main instance)
   int m_owner = -1;
   int m_sel   = 0;
   int m_prio  = 0;
   int m_held  = 0;

   always #5 clk = ~clk;

   rr_arbiter_sel_4ch #(.MAX_HOLD(MAXH)) u_dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .sel(sel), .grant(grant), .busy(busy)
   );

   rr_arbiter_sel_4ch #(.MAX_HOLD(1)) u_dut1 (
      .clk(clk), .rst(rst), .req(req1), .done(done),
      .sel(sel1), .grant(grant1), .busy(busy1)
   );

   rr_pick_4 u_pick (
      .req(pk_req), .prio(pk_prio), .found(pk_found), .idx(pk_idx)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       done;
      logic [1:0] sel;
      logic [3:0] grant;
      logic       busy;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [3:0] rq, input logic d,
                      input logic [1:0] s, input logic [3:0] g, input logic b);
      vec_t v;
      v.rst = r; v.req = rq; v.done = d; v.sel = s; v.grant = g; v.busy = b;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference model written from the arbitration rules, advanced once per edge.
   task automatic model_edge();
      if (rst) begin
         m_owner = -1; m_sel = 0; m_prio = 0; m_held = 0;
      end else if (m_owner < 0) begin
         for (int off = 0; off < 4; off++) begin
            int ch;
            ch = (m_prio + off) % 4;
            if (req[ch] && m_owner < 0) begin
               m_owner = ch; m_sel = ch; m_held = 1;
            end
         end
      end else if (done || !req[m_owner] || m_held >= MAXH) begin
         m_prio  = (m_owner + 1) % 4;
         m_owner = -1;
         m_held  = 0;
      end else begin
         m_held++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".sel"}, int'(sel), m_sel);
      check({tag, ".busy"}, int'(busy), (m_owner >= 0) ? 1 : 0);
      check({tag, ".grant"}, int'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
   endtask

   function automatic int ref_pick(input int rq, input int p);
      for (int off = 0; off < 4; off++)
         if (((rq >> ((p + off) % 4)) & 1) == 1) return (p + off) % 4;
      return -1;
   endfunction

   initial begin
      // exhaustive picker check
      for (int r = 0; r < 16; r++) begin
         for (int p = 0; p < 4; p++) begin
            int exp_i;
            pk_req = 4'(r); pk_prio = 2'(p);
            #1;
            exp_i = ref_pick(r, p);
            check("pick.found", int'(pk_found), (exp_i >= 0) ? 1 : 0);
            if (exp_i >= 0) check("pick.idx", int'(pk_idx), exp_i);
         end
      end

      // vector table (MAX_HOLD=8)
      add(1, 4'b0000, 0, 2'd0, 4'b0000, 0);
      add(0, 4'b0000, 0, 2'd0, 4'b0000, 0);
      add(0, 4'b0100, 0, 2'd2, 4'b0100, 1);
      for (int i = 0; i < 7; i++) add(0, 4'b0100, 0, 2'd2, 4'b0100, 1);
      add(0, 4'b0100, 0, 2'd2, 4'b0000, 0);   // hold limit reached
      add(0, 4'b0100, 0, 2'd2, 4'b0100, 1);   // regrant after one idle
      add(0, 4'b0100, 1, 2'd2, 4'b0000, 0);   // done releases
      add(0, 4'b1010, 0, 2'd3, 4'b1000, 1);
      add(0, 4'b0010, 0, 2'd3, 4'b0000, 0);   // req[3] drops on first cycle
      add(0, 4'b0010, 0, 2'd1, 4'b0010, 1);   // prio wrapped to 0
      add(0, 4'b1010, 1, 2'd1, 4'b0000, 0);   // done with req[1] still high
      add(0, 4'b1010, 0, 2'd3, 4'b1000, 1);   // ch3 next, not ch1
      add(0, 4'b1010, 0, 2'd3, 4'b1000, 1);
      add(1, 4'b1010, 0, 2'd0, 4'b0000, 0);   // reset mid-grant
      add(0, 4'b0110, 0, 2'd1, 4'b0010, 1);
      add(0, 4'b0000, 0, 2'd1, 4'b0000, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; req = tbl[i].req; done = tbl[i].done;
         step();
         check($sformatf("vec%0d.sel", i), int'(sel), int'(tbl[i].sel));
         check($sformatf("vec%0d.grant", i), int'(grant), int'(tbl[i].grant));
         check($sformatf("vec%0d.busy", i), int'(busy), int'(tbl[i].busy));
      end

      // fairness: all requesting, done on third grant cycle
      rst = 1; req = 4'b0000; done = 0;
      step();
      rst = 0; req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         step();
         check("fair.busy1", int'(busy), 1);
         check("fair.sel", int'(sel), g % 4);
         check("fair.grant", int'(grant), 1 << (g % 4));
         step();
         check("fair.busy2", int'(busy), 1);
         step();
         check("fair.busy3", int'(busy), 1);
         done = 1;
         step();
         check("fair.idle", int'(busy), 0);
         check("fair.idle_sel", int'(sel), g % 4);
         done = 0;
      end

      // reset while ch2 holds with count=4
      rst = 1; req = 4'b0000;
      step();
      rst = 0; req = 4'b0100;
      for (int i = 0; i < 4; i++) step();
      check("rstmid.pre_busy", int'(busy), 1);
      rst = 1;
      step();
      check("rstmid.sel", int'(sel), 0);
      check("rstmid.grant", int'(grant), 0);
      check("rstmid.busy", int'(busy), 0);
      rst = 0; req = 4'b0110;
      step();
      check("rstmid.first", int'(sel), 1);
      check("rstmid.first_busy", int'(busy), 1);

      // MAX_HOLD=1 instance: 1-cycle grants alternating with idle
      req = 4'b0000; req1 = 4'b0000; rst = 1;
      step();
      rst = 0; req1 = 4'b0011;
      for (int i = 0; i < 6; i++) begin
         step();
         check("mh1.busy", int'(busy1), (i % 2 == 0) ? 1 : 0);
         if (i % 2 == 0) begin
            check("mh1.sel", int'(sel1), (i / 2) % 2);
            check("mh1.grant", int'(grant1), 1 << ((i / 2) % 2));
         end
      end
      req1 = 4'b0000;

      // randomized compare against the model
      rst = 1; req = 4'b0000; done = 0;
      step();
      check_model("rnd0");
      for (int i = 0; i < 800; i++) begin
         rst  = ($urandom_range(0, 99) == 0);
         req  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) != 0) req = req | sel_bit(2'(m_sel));
         done = ($urandom_range(0, 5) == 0);
         step();
         check_model("rnd");
         check("rnd.onehot", int'($countones(grant) <= 1), 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   function automatic logic [3:0] sel_bit(input logic [1:0] s);
      logic [3:0] v;
      v = 4'b0000;
      v[s] = 1'b1;
      return v;
   endfunction

endmodule
